// File: rtl/ex_mem_stage_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_reg
//   Pipeline register between the EX stage (ALU) and the MEM stage. It
//   captures the ALU result, the flag vector, the destination register and
//   the memory controls of the instruction in EX. It also holds the
//   architectural flags register read by BRFL, and provides a forwarding path
//   back to EX. When an instruction that updates the flags sets the error
//   flag, the block enters a trap state and raises an exception request until
//   the handler acknowledges it.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   stall                 hold all stage contents (MEM busy)
//   flush                 kill the instruction entering this stage
//   ex_*                  instruction currently in EX (valid, result, flags,
//                         flag write enable, rd, reg/mem controls, store data)
//   exc_ack               trap handler acknowledges the exception
//   mem_*                 registered MEM-stage instruction; controls gated by valid
//   flags_q               architectural flags
//                         {overflow, underflow, above, below, error}
//   fwd_en/fwd_rd/fwd_data forwarding of the MEM-stage ALU result to EX
//   exc_pending           error trap outstanding
// ----------------------------------------------------------------------------
module ex_mem_stage_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int FLAG_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [FLAG_W-1:0] ex_flags,
   input  logic              ex_flag_we,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic              exc_ack,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_alu_result,
   output logic [FLAG_W-1:0] mem_flags,
   output logic [REG_AW-1:0] mem_rd,
   output logic              mem_reg_write,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic [DATA_W-1:0] mem_store_data,
   output logic [FLAG_W-1:0] flags_q,
   output logic              fwd_en,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [DATA_W-1:0] fwd_data,
   output logic              exc_pending
);

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } state_t;

   state_t state_q, state_d;
   logic   load;        // RUN edge that accepts the EX instruction
   logic   trap_entry;  // accepted instruction raises the error flag

   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned; that is what keeps a latch from being inferred.
   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      trap_entry = 1'b0;
      case (state_q)
         RUN: begin
            load = ~stall & ~flush;
            if (load && ex_valid && ex_flag_we && ex_flags[0]) begin
               trap_entry = 1'b1;
               state_d    = TRAP;
            end
         end
         TRAP: begin
            // exc_ack outranks stall: the trap path ignores stall entirely.
            if (exc_ack) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid      <= 1'b0;
         mem_alu_result <= '0;
         mem_flags      <= '0;
         mem_rd         <= '0;
         mem_reg_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_store_data <= '0;
         flags_q        <= '0;
      end else if (state_q == TRAP) begin
         // No new instructions while the trap is outstanding; data registers
         // keep the faulting instruction for the handler to inspect.
         mem_valid     <= 1'b0;
         mem_reg_write <= 1'b0;
         mem_mem_read  <= 1'b0;
         mem_mem_write <= 1'b0;
         if (exc_ack) flags_q[0] <= 1'b0;
      end else if (!stall) begin
         // Data fields are captured on flush too; they are don't-care while
         // mem_valid is low, and skipping the enable keeps the datapath simple.
         mem_alu_result <= ex_alu_result;
         mem_flags      <= ex_flags;
         mem_rd         <= ex_rd;
         mem_store_data <= ex_store_data;
         if (load) begin
            mem_valid     <= ex_valid;
            // A faulting instruction must not retire its architectural writes.
            mem_reg_write <= ex_valid & ex_reg_write & ~trap_entry;
            mem_mem_read  <= ex_valid & ex_mem_read;
            mem_mem_write <= ex_valid & ex_mem_write & ~trap_entry;
            if (ex_valid && ex_flag_we) flags_q <= ex_flags;
         end else begin
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
         end
      end
   end

   // Forwarding is driven only from registered state, so there is no
   // combinational path from the EX inputs back to EX.
   assign fwd_en      = mem_valid & mem_reg_write & ~mem_mem_read & (mem_rd != '0);
   assign fwd_rd      = mem_rd;
   assign fwd_data    = mem_alu_result;
   assign exc_pending = (state_q == TRAP);

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage_reg
//   Directed test of ex_mem_stage_reg: reset, load, stall/flush priority,
//   flags-register gating, forwarding enable, the error trap and its
//   acknowledge, and pass-through of the overflow flag.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage_reg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int FLAG_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall, flush, ex_valid, ex_flag_we;
   logic [DATA_W-1:0] ex_alu_result, ex_store_data;
   logic [FLAG_W-1:0] ex_flags;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_write, ex_mem_read, ex_mem_write, exc_ack;
   logic              mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
   logic [DATA_W-1:0] mem_alu_result, mem_store_data, fwd_data;
   logic [FLAG_W-1:0] mem_flags, flags_q;
   logic [REG_AW-1:0] mem_rd, fwd_rd;
   logic              fwd_en, exc_pending;

   int checks   = 0;
   int failures = 0;

   ex_mem_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FLAG_W(FLAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_flags(ex_flags),
      .ex_flag_we(ex_flag_we), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_store_data(ex_store_data), .exc_ack(exc_ack),
      .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
      .mem_flags(mem_flags), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_store_data(mem_store_data), .flags_q(flags_q), .fwd_en(fwd_en),
      .fwd_rd(fwd_rd), .fwd_data(fwd_data), .exc_pending(exc_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one EX-stage instruction.
   task automatic drive(input logic v, input logic [DATA_W-1:0] res,
                        input logic [FLAG_W-1:0] fl, input logic fwe,
                        input logic [REG_AW-1:0] rd, input logic rw,
                        input logic mr, input logic mw,
                        input logic [DATA_W-1:0] sd);
      ex_valid      = v;
      ex_alu_result = res;
      ex_flags      = fl;
      ex_flag_we    = fwe;
      ex_rd         = rd;
      ex_reg_write  = rw;
      ex_mem_read   = mr;
      ex_mem_write  = mw;
      ex_store_data = sd;
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      stall   = 1'b0;
      flush   = 1'b0;
      exc_ack = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      #12;
      check("reset_valid",   64'(mem_valid),   64'd0);
      check("reset_flags",   64'(flags_q),     64'd0);
      check("reset_exc",     64'(exc_pending), 64'd0);
      rst_n = 1'b1;

      // ADD result 0x10, then reset mid-cycle.
      drive(1'b1, 32'h0000_0010, 5'b00000, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("add_result",    64'(mem_alu_result), 64'h10);
      check("add_fwd_en",    64'(fwd_en),         64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid",  64'(mem_valid),      64'd0);
      check("midrst_result", 64'(mem_alu_result), 64'd0);
      check("midrst_rd",     64'(mem_rd),         64'd0);
      check("midrst_rw",     64'(mem_reg_write),  64'd0);
      check("midrst_fwd_en", 64'(fwd_en),         64'd0);
      check("midrst_exc",    64'(exc_pending),    64'd0);
      #1 rst_n = 1'b1;

      // Basic load.
      drive(1'b1, 32'h1234_5678, 5'b00100, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("load_valid",    64'(mem_valid),      64'd1);
      check("load_result",   64'(mem_alu_result), 64'h1234_5678);
      check("load_rd",       64'(mem_rd),         64'd7);
      check("load_mflags",   64'(mem_flags),      64'b00100);
      check("load_fwd_en",   64'(fwd_en),         64'd1);
      check("load_fwd_rd",   64'(fwd_rd),         64'd7);
      check("load_fwd_data", 64'(fwd_data),       64'h1234_5678);
      check("load_flags",    64'(flags_q),        64'b00100);

      // Stall for three cycles with new EX contents.
      stall = 1'b1;
      drive(1'b1, 32'hDEAD_BEEF, 5'b11111, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 32'h1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_result", 64'(mem_alu_result), 64'h1234_5678);
         check("stall_rd",     64'(mem_rd),         64'd7);
         check("stall_mw",     64'(mem_mem_write),  64'd0);
         check("stall_flags",  64'(flags_q),        64'b00100);
      end

      // Flush.
      stall = 1'b0;
      flush = 1'b1;
      step();
      check("flush_valid",  64'(mem_valid),     64'd0);
      check("flush_rw",     64'(mem_reg_write), 64'd0);
      check("flush_mw",     64'(mem_mem_write), 64'd0);
      check("flush_fwd_en", 64'(fwd_en),        64'd0);
      check("flush_flags",  64'(flags_q),       64'b00100);
      flush = 1'b0;

      // AND: flag_we=0 must not touch flags_q.
      drive(1'b1, 32'h0000_00A5, 5'b11111, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("and_valid",  64'(mem_valid), 64'd1);
      check("and_flags",  64'(flags_q),   64'b00100);
      check("and_fwd_en", 64'(fwd_en),    64'd1);

      // Stall and flush together: hold.
      stall = 1'b1;
      flush = 1'b1;
      drive(1'b1, 32'h0000_0BAD, 5'b00010, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      check("sf_valid",  64'(mem_valid),      64'd1);
      check("sf_result", 64'(mem_alu_result), 64'hA5);
      check("sf_flags",  64'(flags_q),        64'b00100);
      stall = 1'b0;
      flush = 1'b0;

      // Invalid instruction with flag_we=1.
      drive(1'b0, 32'h0000_0001, 5'b00010, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 32'h0);
      step();
      check("inv_valid", 64'(mem_valid),     64'd0);
      check("inv_rw",    64'(mem_reg_write), 64'd0);
      check("inv_mr",    64'(mem_mem_read),  64'd0);
      check("inv_mw",    64'(mem_mem_write), 64'd0);
      check("inv_flags", 64'(flags_q),       64'b00100);

      // rd = 0: no forwarding.
      drive(1'b1, 32'h0000_0077, 5'b00000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("rd0_valid",  64'(mem_valid), 64'd1);
      check("rd0_fwd_en", 64'(fwd_en),    64'd0);

      // Load from memory: no forwarding of the address.
      drive(1'b1, 32'h0000_1000, 5'b00000, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h0);
      step();
      check("ld_mr",     64'(mem_mem_read), 64'd1);
      check("ld_fwd_en", 64'(fwd_en),       64'd0);

      // Store.
      drive(1'b1, 32'h0000_2000, 5'b00000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_CAFE);
      step();
      check("st_mw",   64'(mem_mem_write),  64'd1);
      check("st_data", 64'(mem_store_data), 64'hCAFE);

      // DIV by zero: error flag raises the trap.
      drive(1'b1, 32'h0, 5'b00001, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("div_valid",  64'(mem_valid),     64'd1);
      check("div_rw",     64'(mem_reg_write), 64'd0);
      check("div_rd",     64'(mem_rd),        64'd6);
      check("div_exc",    64'(exc_pending),   64'd1);
      check("div_flags",  64'(flags_q),       64'b00001);
      check("div_fwd_en", 64'(fwd_en),        64'd0);

      // In TRAP: instructions ignored, stall ignored, flags held.
      drive(1'b1, 32'h0000_0055, 5'b10000, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("trap_valid", 64'(mem_valid),   64'd0);
      check("trap_exc",   64'(exc_pending), 64'd1);
      check("trap_flags", 64'(flags_q),     64'b00001);
      stall   = 1'b1;
      exc_ack = 1'b1;
      step();
      check("ack_exc",   64'(exc_pending), 64'd0);
      check("ack_flags", 64'(flags_q),     64'b00000);
      check("ack_valid", 64'(mem_valid),   64'd0);
      stall = 1'b0;

      // exc_ack in RUN has no effect; instruction loads normally.
      drive(1'b1, 32'h0000_0055, 5'b00100, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("run_valid",  64'(mem_valid),      64'd1);
      check("run_result", 64'(mem_alu_result), 64'h55);
      check("run_fwd_en", 64'(fwd_en),         64'd1);
      check("run_flags",  64'(flags_q),        64'b00100);
      check("run_exc",    64'(exc_pending),    64'd0);
      exc_ack = 1'b0;

      // Overflow passthrough, no trap.
      drive(1'b1, 32'h8000_0000, 5'b10000, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      check("ovf_result", 64'(mem_alu_result), 64'h8000_0000);
      check("ovf_flags",  64'(flags_q),        64'b10000);
      check("ovf_exc",    64'(exc_pending),    64'd0);
      check("ovf_rw",     64'(mem_reg_write),  64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Pipeline register between the EX stage (ALU) and the MEM stage.
- Captures the ALU result and its 5-bit flag vector, plus destination and memory control for the instruction in EX.
- Holds the architectural flags register that BRFL reads, and exposes a forwarding path back to EX.
- Raises an exception request when an instruction that updates the flags sets the error flag.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data)
- REG_AW, 5, register-file address width
- FLAG_W, 5, flag vector width; bits are [4] overflow, [3] underflow, [2] above, [1] below, [0] error

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all stage contents (MEM busy)
- flush  in  1  kill the instruction entering this stage
- ex_valid  in  1  EX holds a real instruction
- ex_alu_result  in  DATA_W  ALU result
- ex_flags  in  FLAG_W  ALU flag vector
- ex_flag_we  in  1  instruction updates the architectural flags (ADD/SUB/MULT/DIV/CMP)
- ex_rd  in  REG_AW  destination register
- ex_reg_write  in  1  writes the register file
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_store_data  in  DATA_W  store operand
- exc_ack  in  1  trap handler acknowledges the exception
- mem_valid  out  1  MEM-stage instruction valid
- mem_alu_result  out  DATA_W  registered result / memory address
- mem_flags  out  FLAG_W  registered flag vector of the MEM instruction
- mem_rd  out  REG_AW  registered destination
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered controls, gated by valid
- mem_store_data  out  DATA_W  registered store data
- flags_q  out  FLAG_W  architectural flags register, read by BRFL
- fwd_en  out  1  forwarding available: mem_valid & mem_reg_write & ~mem_mem_read & (mem_rd != 0)
- fwd_rd  out  REG_AW  equals mem_rd
- fwd_data  out  DATA_W  equals mem_alu_result
- exc_pending  out  1  error trap outstanding

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0: mem_valid, controls, data, flags_q, exc_pending.
  - FSM goes to RUN.
  - Release of reset is synchronous to clk.
- Latency: 1 cycle from EX inputs to mem_* outputs.
- Priority per edge is reset > trap > stall > flush > load.
- Load (RUN, ~stall, ~flush):
  - mem_valid <= ex_valid; data and rd are captured unconditionally.
  - Controls are captured ANDed with ex_valid.
- Flush (~stall): mem_valid and all three controls <= 0. Data registers may capture, but they are don't-care.
- Stall: every mem_* register holds, and flags_q holds.
  - Stall and flush together: stall wins. The flush is not remembered; upstream reasserts it.
- Flags register:
  - On a load edge with ex_valid & ex_flag_we: flags_q <= ex_flags (whole vector replaced, not OR'd).
  - Otherwise flags_q holds; flushed or invalid instructions never update it.
- FSM states are RUN and TRAP.
  - RUN -> TRAP on a load edge where ex_valid & ex_flag_we & ex_flags[0].
    - On that same edge the faulting instruction enters MEM with mem_reg_write and mem_mem_write forced to 0.
    - flags_q is updated with the error flag set; exc_pending <= 1.
  - TRAP: mem_valid and controls <= 0 every edge regardless of ex_valid; new instructions are not accepted.
    - flags_q holds and the stall input is ignored.
    - exc_ack=1 -> RUN, exc_pending <= 0, flags_q[0] <= 0, other flag bits hold.
  - exc_ack in RUN has no effect.
- fwd_* outputs are combinational from registered state only, with no input-to-output path.
- Overflow/underflow bits are passed through unmodified; this block computes no flags.

Test Plan:
- Reset mid-stream: load ADD result 0x0000_0010, flags 5'b00000, then pull rst_n low between edges -> all outputs 0 immediately, FSM RUN.
- Basic load: ex_valid=1, result 0x1234_5678, rd=7, reg_write=1, flag_we=1, flags 5'b00100 -> next cycle mem_alu_result=0x1234_5678, mem_rd=7, fwd_en=1, flags_q=5'b00100.
- Stall/flush: stall=1 with new ex inputs for 3 cycles -> outputs unchanged. Then stall=0, flush=1 -> mem_valid=0, fwd_en=0, flags_q unchanged. Stall and flush together -> hold.
- Flags update gating:
  - AND instruction with flag_we=0, flags 5'b11111 -> flags_q keeps 5'b00100.
  - Invalid instruction with flag_we=1 -> no update.
  - Load with rd=0 -> fwd_en=0.
- DIV by zero: flag_we=1, flags 5'b00001, reg_write=1 -> mem_valid=1, mem_reg_write=0, exc_pending=1, flags_q=5'b00001.
  - Following valid instructions are ignored; mem_valid=0 while in TRAP.
  - exc_ack -> exc_pending=0, flags_q=5'b00000, next instruction loads normally.
- Overflow passthrough: ADD 0x7FFF_FFFF+1 result 0x8000_0000, flags 5'b10000 -> flags_q=5'b10000, no trap.
